// File: rtl/recip_arbiter.sv
// Round-robin scheduler sharing one multi-cycle reciprocal engine among N requesters.
// Latency: accept edge -> eng_start next cycle; response L+1 cycles after start (L = engine latency).
// Backpressure: one request in flight; req_ready only in IDLE; watchdog overrun halts service until reset.
module recip_arbiter #(
    parameter int W       = 32,
    parameter int N       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid,
    input  logic [N*W-1:0]       req_x,
    output logic [N-1:0]         req_ready,
    output logic [N-1:0]         rsp_valid,
    output logic [W-1:0]         rsp_data,
    output logic                 rsp_invalid,
    output logic                 rsp_timeout,
    output logic                 eng_start,
    output logic [W-1:0]         eng_x,
    input  logic                 eng_done,
    input  logic [W-1:0]         eng_result,
    input  logic                 eng_invalid,
    output logic                 busy,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 fault
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP, S_FAULT} state_t;

    state_t         state, state_nx;
    logic [IW-1:0]  last_grant;
    logic [CW-1:0]  wd_cnt;
    logic [IW-1:0]  win;
    logic [IW-1:0]  cand;
    logic           found;
    logic           wd_hit;
    logic [W-1:0]   x_arr [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            x_arr[i] = req_x[i*W +: W];
        end
    end

    // Scan starts just after the last grant so the previous winner ends up with the lowest priority.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = last_grant;
        for (int k = 0; k < N; k++) begin
            cand = (cand == IW'(N-1)) ? '0 : cand + 1'b1;
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign wd_hit = (wd_cnt == CW'(TIMEOUT-1));

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_ready[i] = rst_n && (state == S_IDLE) && found && (win == IW'(i));
            rsp_valid[i] = (state == S_RESP) && (grant_id == IW'(i));
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (found) state_nx = S_LAUNCH;
            S_LAUNCH: state_nx = S_WAIT;
            S_WAIT:   if (eng_done || wd_hit) state_nx = S_RESP;
            S_RESP:   state_nx = fault ? S_FAULT : S_IDLE;
            S_FAULT:  state_nx = S_FAULT;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            last_grant  <= IW'(N-1);
            wd_cnt      <= '0;
            eng_x       <= '0;
            grant_id    <= '0;
            rsp_data    <= '0;
            rsp_invalid <= 1'b0;
            rsp_timeout <= 1'b0;
            fault       <= 1'b0;
            eng_start   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state     <= state_nx;
            eng_start <= (state_nx == S_LAUNCH);
            busy      <= (state_nx != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (found) begin
                        eng_x    <= x_arr[win];
                        grant_id <= win;
                    end
                end
                S_LAUNCH: wd_cnt <= '0;
                S_WAIT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    // A done landing on the last watchdog cycle still counts as a clean run.
                    if (eng_done) begin
                        rsp_data    <= eng_result;
                        rsp_invalid <= eng_invalid;
                        rsp_timeout <= 1'b0;
                    end else if (wd_hit) begin
                        rsp_data    <= '0;
                        rsp_invalid <= 1'b1;
                        rsp_timeout <= 1'b1;
                        fault       <= 1'b1;
                    end
                end
                S_RESP: last_grant <= grant_id;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_recip_arbiter.sv
// Directed bench for recip_arbiter: inputs change on the falling edge, outputs checked mid-cycle.
module tb_recip_arbiter;
    localparam int W       = 32;
    localparam int N       = 4;
    localparam int TIMEOUT = 64;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_x;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           rsp_invalid;
    logic           rsp_timeout;
    logic           eng_start;
    logic [W-1:0]   eng_x;
    logic           eng_done;
    logic [W-1:0]   eng_result;
    logic           eng_invalid;
    logic           busy;
    logic [1:0]     grant_id;
    logic           fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    recip_arbiter #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_invalid(rsp_invalid), .rsp_timeout(rsp_timeout),
        .eng_start(eng_start), .eng_x(eng_x),
        .eng_done(eng_done), .eng_result(eng_result), .eng_invalid(eng_invalid),
        .busy(busy), .grant_id(grant_id), .fault(fault)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".req_ready"},   req_ready,   0);
        chk({tag, ".rsp_valid"},   rsp_valid,   0);
        chk({tag, ".rsp_data"},    rsp_data,    0);
        chk({tag, ".rsp_invalid"}, rsp_invalid, 0);
        chk({tag, ".rsp_timeout"}, rsp_timeout, 0);
        chk({tag, ".eng_start"},   eng_start,   0);
        chk({tag, ".eng_x"},       eng_x,       0);
        chk({tag, ".busy"},        busy,        0);
        chk({tag, ".grant_id"},    grant_id,    0);
        chk({tag, ".fault"},       fault,       0);
    endtask

    // Called at a falling edge in IDLE with req_valid already driven; returns at the IDLE falling edge after RESP.
    task automatic serve(input int g, input logic [W-1:0] x, input int lat,
                         input logic [W-1:0] res, input logic inv, input logic [N-1:0] drop);
        logic [N-1:0] onehot;
        onehot    = '0;
        onehot[g] = 1'b1;
        #1 chk("grant_ready", req_ready, onehot);
        step();
        req_valid         = req_valid & ~drop;
        req_x[g*W +: W]   = 32'hDEAD_BEEF;
        #1;
        chk("launch_start", eng_start, 1);
        chk("launch_x", eng_x, x);
        chk("launch_gid", grant_id, g);
        chk("launch_busy", busy, 1);
        chk("launch_ready", req_ready, 0);
        for (int j = 1; j <= lat; j++) begin
            step();
            if (j == 1) chk("start_pulse_end", eng_start, 0);
            chk("wait_no_rsp", rsp_valid, 0);
            chk("wait_x_stable", eng_x, x);
            if (j == lat) begin
                eng_done    = 1'b1;
                eng_result  = res;
                eng_invalid = inv;
            end
        end
        step();
        eng_done    = 1'b0;
        eng_result  = '0;
        eng_invalid = 1'b0;
        chk("rsp_valid", rsp_valid, onehot);
        chk("rsp_data", rsp_data, res);
        chk("rsp_invalid", rsp_invalid, inv);
        chk("rsp_timeout", rsp_timeout, 0);
        chk("rsp_fault", fault, 0);
        req_x[g*W +: W] = x;
        step();
        chk("after_rsp_valid", rsp_valid, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = '0;
        eng_done    = 1'b0;
        eng_result  = '0;
        eng_invalid = 1'b0;
        for (int i = 0; i < N; i++) req_x[i*W +: W] = W'((i + 1) << 16);
        step();
        step();
        chk_reset_outs("reset");

        // All requesters hold valid from reset: grants must rotate 0,1,2,3,0.
        req_valid = 4'hF;
        #1 chk("ready_in_reset", req_ready, 0);
        step();
        rst_n = 1'b1;
        serve(0, 32'h0001_0000, 1, 32'h0001_0000, 1'b0, 4'h0);
        serve(1, 32'h0002_0000, 1, 32'h0000_8000, 1'b0, 4'h0);
        serve(2, 32'h0003_0000, 1, 32'h0000_5555, 1'b0, 4'h0);
        serve(3, 32'h0004_0000, 1, 32'h0000_4000, 1'b0, 4'h0);
        serve(0, 32'h0001_0000, 1, 32'h0001_0000, 1'b0, 4'hF);
        #1 chk("rr_idle_ready", req_ready, 0);
        chk("rr_idle_busy", busy, 0);

        // Single request, 2.0 -> 0.5 with a 10-cycle engine.
        req_valid = 4'b0010;
        serve(1, 32'h0002_0000, 10, 32'h0000_8000, 1'b0, 4'b0010);
        #1 chk("single_idle_ready", req_ready, 0);

        // Negative operand reported invalid by the engine.
        req_valid            = 4'b0100;
        req_x[2*W +: W]      = 32'hFFFF_0000;
        serve(2, 32'hFFFF_0000, 3, 32'h0, 1'b1, 4'b0100);

        // Done on the final watchdog cycle wins over the timeout.
        req_valid = 4'b0010;
        serve(1, 32'h0002_0000, TIMEOUT, 32'h0000_8000, 1'b0, 4'b0010);
        #1 chk("collision_fault", fault, 0);

        // Reset during WAIT, then a stale done; the next grant must come from a fresh rotation.
        req_valid = 4'b0100;
        #1 chk("midrun_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        step();
        step();
        rst_n = 1'b0;
        #1 chk_reset_outs("midrun_reset");
        step();
        rst_n      = 1'b1;
        eng_done   = 1'b1;
        eng_result = 32'h1234;
        step();
        eng_done = 1'b0;
        chk("stale_done_rsp", rsp_valid, 0);
        chk("stale_done_busy", busy, 0);
        step();
        chk("stale_done_rsp2", rsp_valid, 0);
        req_valid = 4'b0101;
        serve(0, 32'h0001_0000, 2, 32'h0001_0000, 1'b0, 4'b0101);

        // Engine never answers: timeout response, then sticky fault.
        req_valid = 4'b0001;
        #1 chk("wd_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        #1 chk("wd_start", eng_start, 1);
        for (int j = 1; j <= TIMEOUT; j++) begin
            step();
            chk("wd_wait_no_rsp", rsp_valid, 0);
        end
        step();
        chk("wd_rsp_valid", rsp_valid, 4'b0001);
        chk("wd_rsp_data", rsp_data, 0);
        chk("wd_rsp_invalid", rsp_invalid, 1);
        chk("wd_rsp_timeout", rsp_timeout, 1);
        chk("wd_fault_set", fault, 1);
        step();
        chk("fault_state", fault, 1);
        chk("fault_busy", busy, 1);
        chk("fault_no_rsp", rsp_valid, 0);
        req_valid = 4'hF;
        #1 chk("fault_ready", req_ready, 0);
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk("fault_ignore_done", rsp_valid, 0);
        chk("fault_ready2", req_ready, 0);
        chk("fault_sticky", fault, 1);
        rst_n = 1'b0;
        #1 chk_reset_outs("fault_reset");
        req_valid = '0;
        step();
        rst_n = 1'b1;
        step();
        chk("fault_cleared", fault, 0);
        chk("post_fault_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
